// File: rtl/mips_hazard_pkg.sv
// Shared types and helpers for the MIPS hazard/forwarding control slice.
package mips_hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Register-address width carried in the stage shadows; REG_AW must not exceed it.
    localparam int STG_AW = 5;
    localparam logic [STG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              regwrite;
        logic              memtoreg;
        logic [STG_AW-1:0] writereg;
    } stage_info_t;

    // EX operand select: MEM result beats WB result, $0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [STG_AW-1:0] src,
                                           input stage_info_t m, input stage_info_t w);
        if (src != REG_ZERO && m.regwrite && m.writereg == src) return FWD_MEM;
        if (src != REG_ZERO && w.regwrite && w.writereg == src) return FWD_WB;
        return FWD_RF;
    endfunction

    function automatic logic src_hit(input logic use_rs, input logic [STG_AW-1:0] rs,
                                     input logic use_rt, input logic [STG_AW-1:0] rt,
                                     input logic [STG_AW-1:0] wr);
        return (wr != REG_ZERO) && ((use_rs && rs == wr) || (use_rt && rt == wr));
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// Resettable shadow register for one pipeline stage's destination info; bubble loads zero.
module hazard_stage_reg
    import mips_hazard_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bubble,
    input  stage_info_t d,
    output stage_info_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      q <= '0;
        else if (bubble) q <= '0;
        else             q <= d;
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard unit: EX/ID forwarding selects, load-use and branch stalls, saturating stall counter.
module hazard_forward_ctrl
    import mips_hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs_d,
    input  logic [REG_AW-1:0] rt_d,
    input  logic              use_rs_d,
    input  logic              use_rt_d,
    input  logic              regwrite_d,
    input  logic              memtoreg_d,
    input  logic [REG_AW-1:0] writereg_d,
    input  logic              branch_d,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic              forward_a_d,
    output logic              forward_b_d,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_e,
    output logic [CNT_W-1:0]  stall_count
);

    logic [STG_AW-1:0] rs_w, rt_w, rs_e, rt_e;
    stage_info_t       info_d, e_q, m_q, w_q;
    logic              stall, lwstall, brstall;

    assign rs_w   = STG_AW'(rs_d);
    assign rt_w   = STG_AW'(rt_d);
    assign info_d = '{regwrite: regwrite_d, memtoreg: memtoreg_d, writereg: STG_AW'(writereg_d)};

    hazard_stage_reg u_stg_e (.clk(clk), .rst_n(rst_n), .bubble(stall), .d(info_d), .q(e_q));
    hazard_stage_reg u_stg_m (.clk(clk), .rst_n(rst_n), .bubble(1'b0),  .d(e_q),    .q(m_q));
    hazard_stage_reg u_stg_w (.clk(clk), .rst_n(rst_n), .bubble(1'b0),  .d(m_q),    .q(w_q));

    // Unused source fields are zeroed so they can never match a writer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_e <= REG_ZERO;
            rt_e <= REG_ZERO;
        end else if (stall) begin
            rs_e <= REG_ZERO;
            rt_e <= REG_ZERO;
        end else begin
            rs_e <= use_rs_d ? rs_w : REG_ZERO;
            rt_e <= use_rt_d ? rt_w : REG_ZERO;
        end
    end

    assign lwstall = e_q.memtoreg && src_hit(use_rs_d, rs_w, use_rt_d, rt_w, e_q.writereg);
    assign brstall = branch_d &&
                     ((e_q.regwrite && src_hit(use_rs_d, rs_w, use_rt_d, rt_w, e_q.writereg)) ||
                      (m_q.memtoreg && src_hit(use_rs_d, rs_w, use_rt_d, rt_w, m_q.writereg)));
    assign stall   = lwstall | brstall;

    assign stall_f = stall;
    assign stall_d = stall;
    assign flush_e = stall;

    assign forward_a_e = fwd_sel(rs_e, m_q, w_q);
    assign forward_b_e = fwd_sel(rt_e, m_q, w_q);

    // Register file is write-first, so ID only needs the MEM path.
    assign forward_a_d = (rs_w != REG_ZERO) && m_q.regwrite && (m_q.writereg == rs_w);
    assign forward_b_d = (rt_w != REG_ZERO) && m_q.regwrite && (m_q.writereg == rt_w);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          stall_count <= '0;
        else if (stall && stall_count != '1) stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: forwarding, stalls, $0 handling, counter saturation.
module tb_hazard_forward_ctrl;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [REG_AW-1:0] rs_d, rt_d, writereg_d;
    logic              use_rs_d, use_rt_d, regwrite_d, memtoreg_d, branch_d;
    logic [1:0]        forward_a_e, forward_b_e;
    logic              forward_a_d, forward_b_d, stall_f, stall_d, flush_e;
    logic [CNT_W-1:0]  stall_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
        .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .writereg_d(writereg_d),
        .branch_d(branch_d),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .forward_a_d(forward_a_d), .forward_b_d(forward_b_d),
        .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
        .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input int rs, input int rt, input logic urs, input logic urt,
                          input logic rw, input logic mtr, input int wr, input logic br);
        rs_d = REG_AW'(rs); rt_d = REG_AW'(rt); use_rs_d = urs; use_rt_d = urt;
        regwrite_d = rw; memtoreg_d = mtr; writereg_d = REG_AW'(wr); branch_d = br;
    endtask

    // Start a new cycle with the given ID instruction, then sample at the falling edge.
    task automatic put(input int rs, input int rt, input logic urs, input logic urt,
                       input logic rw, input logic mtr, input int wr, input logic br);
        @(posedge clk); #1;
        set_id(rs, rt, urs, urt, rw, mtr, wr, br);
        @(negedge clk);
    endtask

    task automatic nop();   put(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic alu(input int wr);  put(0, 0, 0, 0, 1, 0, wr, 0); endtask
    task automatic lw(input int wr);   put(0, 0, 0, 0, 1, 1, wr, 0); endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, "_stall_f"}, stall_f, exp);
        chk({tag, "_stall_d"}, stall_d, exp);
        chk({tag, "_flush_e"}, flush_e, exp);
    endtask

    initial begin
        // Reset with busy-looking inputs: everything must read zero.
        rst_n = 1'b0;
        set_id(8, 9, 1, 1, 1, 1, 8, 1);
        repeat (2) @(negedge clk);
        chk("rst_fwd_a_e", forward_a_e, 2'b00);
        chk("rst_fwd_b_e", forward_b_e, 2'b00);
        chk("rst_fwd_a_d", forward_a_d, 1'b0);
        chk_stall("rst", 1'b0);
        chk("rst_count", stall_count, 0);
        rst_n = 1'b1;
        nop();
        chk("idle_fwd_a_e", forward_a_e, 2'b00);
        chk_stall("idle", 1'b0);
        chk("idle_count", stall_count, 0);
        repeat (2) nop();

        // ALU -> consumer: MEM forward
        alu(8);
        put(8, 0, 1, 0, 1, 0, 12, 0);
        chk_stall("alu_adj", 1'b0);
        chk("alu_adj_fwd_a_d", forward_a_d, 1'b0);
        nop();
        chk("alu_mem_fwd_a_e", forward_a_e, 2'b10);
        chk("alu_mem_fwd_b_e", forward_b_e, 2'b00);

        // ALU, independent, consumer: WB forward on operand B
        alu(8);
        alu(20);
        put(0, 8, 0, 1, 1, 0, 13, 0);
        nop();
        chk("alu_wb_fwd_b_e", forward_b_e, 2'b01);
        chk("alu_wb_fwd_a_e", forward_a_e, 2'b00);

        // Writer in both M and W: MEM has priority
        alu(8);
        alu(8);
        put(8, 0, 1, 0, 1, 0, 14, 0);
        chk("both_fwd_a_d", forward_a_d, 1'b1);
        nop();
        chk("both_fwd_a_e", forward_a_e, 2'b10);
        repeat (3) nop();

        // Load-use: one stall cycle, then WB forward
        lw(9);
        put(0, 9, 0, 1, 1, 0, 13, 0);
        chk_stall("lu_1", 1'b1);
        chk("lu_1_count", stall_count, 0);
        put(0, 9, 0, 1, 1, 0, 13, 0);
        chk_stall("lu_2", 1'b0);
        chk("lu_2_count", stall_count, 1);
        nop();
        chk("lu_fwd_b_e", forward_b_e, 2'b01);
        repeat (3) nop();

        // Branch after ALU: one stall, then ID forward for one cycle
        alu(10);
        put(10, 0, 1, 1, 0, 0, 0, 1);
        chk_stall("br_alu_1", 1'b1);
        chk("br_alu_1_fwd_a_d", forward_a_d, 1'b0);
        put(10, 0, 1, 1, 0, 0, 0, 1);
        chk_stall("br_alu_2", 1'b0);
        chk("br_alu_2_fwd_a_d", forward_a_d, 1'b1);
        chk("br_alu_count", stall_count, 2);
        nop();
        chk("br_alu_3_fwd_a_d", forward_a_d, 1'b0);
        repeat (3) nop();

        // Branch after load: two stalls, resolved from register file
        lw(11);
        put(0, 11, 1, 1, 0, 0, 0, 1);
        chk_stall("br_lw_1", 1'b1);
        put(0, 11, 1, 1, 0, 0, 0, 1);
        chk_stall("br_lw_2", 1'b1);
        put(0, 11, 1, 1, 0, 0, 0, 1);
        chk_stall("br_lw_3", 1'b0);
        chk("br_lw_fwd_b_d", forward_b_d, 1'b0);
        chk("br_lw_count", stall_count, 4);
        repeat (3) nop();

        // $0: loads/writes to register 0 never stall or forward
        lw(0);
        put(0, 0, 1, 1, 1, 0, 0, 1);
        chk_stall("zero_1", 1'b0);
        put(0, 0, 1, 1, 0, 0, 0, 1);
        chk_stall("zero_2", 1'b0);
        chk("zero_fwd_a_d", forward_a_d, 1'b0);
        chk("zero_fwd_a_e", forward_a_e, 2'b00);
        chk("zero_fwd_b_e", forward_b_e, 2'b00);
        chk("zero_count", stall_count, 4);

        // 20 load-use stalls: counter climbs 4 -> 15 and holds
        for (int i = 0; i < 20; i++) begin
            lw(9);
            put(9, 0, 1, 0, 1, 1, 9, 0);
            if (i == 3) chk("sat_mid_count", stall_count, 7);
        end
        nop();
        chk("sat_count", stall_count, 15);
        repeat (2) nop();

        // Reset asserted mid-stall clears everything at once
        lw(9);
        put(0, 9, 0, 1, 0, 0, 0, 0);
        chk_stall("mid_pre", 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk_stall("mid_rst", 1'b0);
        chk("mid_rst_count", stall_count, 0);
        #1 rst_n = 1'b1;
        put(0, 9, 0, 1, 0, 0, 0, 0);
        chk_stall("post_rst", 1'b0);
        chk("post_rst_fwd_b_e", forward_b_e, 2'b00);
        chk("post_rst_count", stall_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
Control-side counterpart of the datapath forwarding muxes in the stalling/forwarding pipelined MIPS core. It tracks destination-register info for instructions in EX/MEM/WB in internal shadow registers. From that state it drives:
- the 2-bit select codes for the EX-stage 3-input operand muxes;
- the 1-bit select codes for the ID-stage branch-compare 2-input muxes;
- the F/D stall and E flush controls.
It also keeps a saturating count of stall cycles for performance measurement.

Parameters:
REG_AW, 5, register-address width
CNT_W, 32, stall-counter width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
rs_d  in  REG_AW  rs field of instruction in ID
rt_d  in  REG_AW  rt field of instruction in ID
use_rs_d  in  1  ID instruction reads rs
use_rt_d  in  1  ID instruction reads rt
regwrite_d  in  1  ID instruction writes register file
memtoreg_d  in  1  ID instruction is a load
writereg_d  in  REG_AW  destination register of ID instruction
branch_d  in  1  ID instruction is a branch (compare resolved in ID)
forward_a_e  out  2  select for EX operand-A 3-input mux
forward_b_e  out  2  select for EX operand-B 3-input mux
forward_a_d  out  1  select for ID branch-compare A 2-input mux
forward_b_d  out  1  select for ID branch-compare B 2-input mux
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID register
flush_e  out  1  insert bubble into ID/EX
stall_count  out  CNT_W  cycles with stall asserted

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low. While it is low, all shadow state and stall_count clear to 0, so all outputs read 0 (selects 00 = register file, no stall).
- Shadow stages, updated every rising edge:
  - E stage loads {rs_d masked by use_rs_d, rt_d masked by use_rt_d, regwrite_d, memtoreg_d, writereg_d}.
  - When stall=1, E loads all-zero instead (bubble).
  - M loads {regwrite, memtoreg, writereg} from E. W loads the same fields from M.
  - M and W never stall.
- Select encoding matches the mux: s[1] selects d2 and has priority, s[0] selects d1.
  - 2'b10 = MEM ALU result (d2)
  - 2'b01 = WB result (d1)
  - 2'b00 = register file (d0)
  - 2'b11 is never driven.
- forward_a_e is purely a function of registered state:
  - 10 if rs_e!=0 && regwrite_m && writereg_m==rs_e;
  - else 01 if rs_e!=0 && regwrite_w && writereg_w==rs_e;
  - else 00.
  - forward_b_e is identical using rt_e. MEM wins over WB when both match.
- forward_a_d = rs_d!=0 && regwrite_m && writereg_m==rs_d. forward_b_d is the same with rt_d. No WB forward in ID: the register file is write-first.
- Load-use stall (lwstall): memtoreg_e && writereg_e!=0 && ((use_rs_d && rs_d==writereg_e) || (use_rt_d && rt_d==writereg_e)).
- Branch stall (brstall): branch_d && match, where match is either of:
  - regwrite_e && writereg_e!=0 && writereg_e equals rs_d or rt_d;
  - memtoreg_m && writereg_m!=0 && writereg_m equals rs_d or rt_d.
  - Only operands whose use flag is set count.
- stall = lwstall | brstall. It is combinational from the ID inputs plus registered state, with zero latency in the same cycle. stall_f = stall_d = flush_e = stall.
- A stalled instruction re-presents the same ID inputs next cycle. Because the bubble has advanced, a load-use stall lasts exactly 1 cycle. A branch after an ALU op stalls 1 cycle; a branch after a load stalls 2 cycles.
- Register 0 is never forwarded and never causes a stall.
- stall_count increments on each edge where stall=1 and saturates at all-ones (no wrap).
- If reset asserts mid-stall, everything clears immediately. The first cycle after release has an empty pipeline.

Decomposition:
- Shared package mips_hazard_pkg holds:
  - constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, REG_ZERO;
  - the stage-info struct {regwrite, memtoreg, writereg}.
- One sub-module, hazard_stage_reg: a resettable register slice for stage info with a bubble input. Instantiated for E, M and W.

Test Plan:
- Reset: hold rst_n=0 with arbitrary inputs -> all outputs 0, stall_count=0. Release -> still 0 with an idle pipeline.
- ALU chain: add $8 (regwrite, writereg=8), then an instruction with use_rs rs=8 -> when consumer is in E, forward_a_e=10. An independent instruction between them gives 01 instead. Writer in both M and W gives 10.
- Load-use: lw $9, then consumer rt=9 -> stall_f/stall_d/flush_e=1 for exactly 1 cycle. Next cycle forward_b_e=01. stall_count=1.
- Branch after ALU: add $10, then beq rs=10 -> 1 stall cycle, then forward_a_d=1 for 1 cycle.
- Branch after load: lw $11, then beq rt=11 -> 2 stall cycles, no forward_b_d. stall_count=2.
- $0 and saturation: writes to reg 0 with readers of reg 0 -> no forward, no stall. With CNT_W=4, 20 consecutive stall cycles -> stall_count holds 15.
